ldtu_atu_packer: RTL and testbench
==================================

# ldtu_atu_packer

Test-mode data source for the LiTE-DTU output mux: captures paired 12-bit samples from the gain-1 and gain-10 ADCs, packs two consecutive samples per gain into tagged 32-bit words, and distributes them round-robin over the four ATU lanes. Its outputs drive the DATA32_ATU_0..3 inputs of the output data mux, which selects them whenever TEST_ENABLE is high. A start-of-stream sync word lets the back-end lock lane alignment.

## Interface
- Nbits_12, 12, ADC sample width
- Nbits_32, 32, lane word width
- CLK  in  1  160 MHz system clock, the single clock of the block
- rst_b  in  1  asynchronous active-low reset
- test_enable  in  1  ATU stream enable (level)
- sample_valid  in  1  both DATA12 inputs carry a new sample this cycle
- DATA12_g01  in  12  gain-1 ADC sample
- DATA12_g10  in  12  gain-10 ADC sample
- sync_pattern  in  32  word emitted on all lanes at stream start
- DATA32_ATU_0..3  out  32 each  lane words, registered
- atu_load  out  1  one-cycle strobe: at least one lane updated this cycle
- atu_active  out  1  high in SYNC and RUN

## Operation
- States: IDLE, SYNC, RUN.
  - IDLE → SYNC on an edge with test_enable=1.
  - SYNC → RUN unconditionally after 1 cycle.
  - Any state → IDLE on an edge with test_enable=0; this has priority over everything else.
- SYNC edge actions:
  - All four lanes load sync_pattern; atu_load=1.
  - seq and the half flag clear.
  - Samples presented in IDLE or SYNC are ignored.
- RUN, sample_valid=1, half=0: store both samples as "older"; set half=1. No lane update.
- RUN, sample_valid=1, half=1: emit a pair; half=0; seq increments.
  - g10 word = {2'b10, seq[5:0], older_g10, DATA12_g10}.
  - g01 word = {2'b01, seq[5:0], older_g01, DATA12_g01}.
  - Even seq → g10 on lane 0, g01 on lane 1. Odd seq → g10 on lane 2, g01 on lane 3.
  - Non-addressed lanes hold their value.
- seq is a 6-bit counter that wraps 63 → 0 with no flag.
- Falling test_enable:
  - A pending half pair is discarded.
  - Lanes hold their last value; atu_load=0.
  - Re-enable restarts with SYNC and seq=0.
- Reset values: lanes 0x00000000; atu_load 0; atu_active 0; state IDLE; seq 0; half 0.
- Reset asserted mid-stream clears all state immediately (asynchronous).

## Timing
- Lane update is visible 1 cycle after the edge that captures the second sample of a pair.
- The fastest pair rate is one per 2 cycles (sample_valid held high), so lanes never collide.
- sync_pattern is sampled on the SYNC edge only.
- atu_load is high for exactly the cycle following each SYNC or pair-emit edge.
- An idle gap between the two samples of a pair is legal; half persists until the next valid sample or IDLE.

## Configuration
- LDTU_ATU_PARITY_EN defined:
  - Bit 29 of each data word becomes even parity over bits [28:0], so XOR of [29:0] is 0.
  - The sequence field shrinks to seq[4:0] in bits [28:24]; the internal counter stays 6 bits.
  - Lane selection still uses seq[0].
- Undefined: the full 6-bit seq occupies bits [29:24]. Sync words are never modified.

## Structure
- Package ldtu_atu_pkg holds:
  - tag constants TAG_G10=2'b10 and TAG_G01=2'b01;
  - the state enum (IDLE, SYNC, RUN);
  - the field position constants.
- One sub-module, ldtu_atu_word_fmt: combinational formatter taking tag, seq, older and newer sample and producing the 32-bit word, including the parity option. It is instantiated twice, once per gain.

## Test plan
- Assert rst_b=0 mid-stream → all lanes 0, atu_load 0, atu_active 0 within the reset cycle.
- test_enable 0→1 with sync_pattern=0x5A5A5A5A → next cycle all lanes 0x5A5A5A5A, atu_load=1 for one cycle, then atu_active stays 1.
- RUN; valid pairs g10 0x123 then 0x456, g01 0x789 then 0xABC → lane0=0x80123456, lane1=0x40789ABC; lanes 2 and 3 still hold 0x5A5A5A5A.
- Second pair g10 0x001/0x002, g01 0x003/0x004 → lane2=0x81001002, lane3=0x41003004; lanes 0 and 1 unchanged.
- 65 consecutive pairs → pair 65 carries seq 0 on lanes 0 and 1; with LDTU_ATU_PARITY_EN, check that XOR of bits [29:0] is 0 on every data word.
- Drop test_enable after one sample, re-enable → SYNC repeats, the discarded half is never emitted, and the first new pair has seq 0 on lanes 0 and 1.

Source files
------------

// File: rtl/ldtu_atu_pkg.sv
// ldtu_atu_pkg
// Shared definitions for the LiTE-DTU ATU test-mode packer: lane word tags,
// the packer state encoding and the bit positions of the 32-bit lane word.
// Optional feature macro: LDTU_ATU_PARITY_EN (bit 29 becomes even parity and
// the sequence field narrows to 5 bits).
package ldtu_atu_pkg;

  localparam int SAMPLE_W = 12;
  localparam int WORD_W   = 32;
  localparam int SEQ_W    = 6;

  localparam logic [1:0] TAG_G10 = 2'b10;
  localparam logic [1:0] TAG_G01 = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Lane word layout: {tag[31:30], seq/parity[29:24], older[23:12], newer[11:0]}
  localparam int TAG_LSB = 30;
  localparam int PAR_BIT = 29;
  localparam int SEQ_LSB = 24;
  localparam int OLD_LSB = 12;
  localparam int NEW_LSB = 0;

`ifdef LDTU_ATU_PARITY_EN
  localparam int SEQ_FIELD_W = 5;
`else
  localparam int SEQ_FIELD_W = 6;
`endif

endpackage

// File: rtl/ldtu_atu_word_fmt.sv
// ldtu_atu_word_fmt
// Combinational formatter building one tagged 32-bit ATU lane word from a tag,
// the sequence field and an older/newer 12-bit sample pair.
// Ports:
//   i_tag   [1:0]            gain tag placed in bits [31:30]
//   i_seq   [SEQ_FIELD_W-1:0] sequence field (6 bits, or 5 with parity)
//   i_older [11:0]           first sample of the pair, bits [23:12]
//   i_newer [11:0]           second sample of the pair, bits [11:0]
//   o_word  [31:0]           formatted lane word
// Optional feature macro: LDTU_ATU_PARITY_EN -- bit 29 carries even parity
// over bits [28:0] so that the XOR of bits [29:0] is zero.
module ldtu_atu_word_fmt
  import ldtu_atu_pkg::*;
(
  input  logic [1:0]             i_tag,
  input  logic [SEQ_FIELD_W-1:0] i_seq,
  input  logic [SAMPLE_W-1:0]    i_older,
  input  logic [SAMPLE_W-1:0]    i_newer,
  output logic [WORD_W-1:0]      o_word
);

`ifdef LDTU_ATU_PARITY_EN
  logic [PAR_BIT-1:0] w_body;

  always_comb begin
    w_body = {i_seq, i_older, i_newer};
    o_word = {i_tag, ^w_body, w_body};
  end
`else
  always_comb begin
    o_word = {i_tag, i_seq, i_older, i_newer};
  end
`endif

endmodule

// File: rtl/ldtu_atu_packer.sv
// ldtu_atu_packer
// Test-mode data source for the LiTE-DTU output mux. Pairs consecutive gain-1
// and gain-10 ADC samples into tagged 32-bit words and spreads them over the
// four ATU lanes (even seq -> lanes 0/1, odd seq -> lanes 2/3). Entering the
// stream emits sync_pattern on all lanes so the back-end can align lanes.
// Ports:
//   CLK              160 MHz system clock
//   rst_b            asynchronous active-low reset
//   test_enable      stream enable (level); low forces IDLE immediately
//   sample_valid     both DATA12 inputs carry a new sample this cycle
//   DATA12_g01/g10   12-bit ADC samples
//   sync_pattern     word loaded on all lanes at stream start
//   DATA32_ATU_0..3  registered lane words
//   atu_load         one-cycle strobe, some lane updated on the previous edge
//   atu_active       high in SYNC and RUN
// Optional feature macro: LDTU_ATU_PARITY_EN (see ldtu_atu_word_fmt).
module ldtu_atu_packer
  import ldtu_atu_pkg::*;
#(
  parameter int Nbits_12 = 12,
  parameter int Nbits_32 = 32
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic                test_enable,
  input  logic                sample_valid,
  input  logic [Nbits_12-1:0] DATA12_g01,
  input  logic [Nbits_12-1:0] DATA12_g10,
  input  logic [Nbits_32-1:0] sync_pattern,
  output logic [Nbits_32-1:0] DATA32_ATU_0,
  output logic [Nbits_32-1:0] DATA32_ATU_1,
  output logic [Nbits_32-1:0] DATA32_ATU_2,
  output logic [Nbits_32-1:0] DATA32_ATU_3,
  output logic                atu_load,
  output logic                atu_active
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEQ_W-1:0]    r_seq;
  logic                r_half;
  logic [Nbits_12-1:0] r_old_g01;
  logic [Nbits_12-1:0] r_old_g10;
  logic                w_enter_sync;
  logic                w_take_first;
  logic                w_emit;
  logic [Nbits_32-1:0] w_word_g10;
  logic [Nbits_32-1:0] w_word_g01;

  // Dropping test_enable wins over every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (!test_enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = SYNC;
        SYNC:    w_state_nxt = RUN;
        RUN:     w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Samples only count while already in RUN; those seen in IDLE/SYNC are dropped.
  always_comb begin
    w_enter_sync = test_enable && (r_state == IDLE);
    w_take_first = test_enable && (r_state == RUN) && sample_valid && !r_half;
    w_emit       = test_enable && (r_state == RUN) && sample_valid && r_half;
  end

  ldtu_atu_word_fmt u_fmt_g10 (
    .i_tag   (TAG_G10),
    .i_seq   (r_seq[SEQ_FIELD_W-1:0]),
    .i_older (r_old_g10),
    .i_newer (DATA12_g10),
    .o_word  (w_word_g10)
  );

  ldtu_atu_word_fmt u_fmt_g01 (
    .i_tag   (TAG_G01),
    .i_seq   (r_seq[SEQ_FIELD_W-1:0]),
    .i_older (r_old_g01),
    .i_newer (DATA12_g01),
    .o_word  (w_word_g01)
  );

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= IDLE;
      r_seq        <= '0;
      r_half       <= 1'b0;
      atu_load     <= 1'b0;
      DATA32_ATU_0 <= '0;
      DATA32_ATU_1 <= '0;
      DATA32_ATU_2 <= '0;
      DATA32_ATU_3 <= '0;
    end else begin
      r_state  <= w_state_nxt;
      atu_load <= w_enter_sync || w_emit;
      // A half pair left pending when the stream stops is discarded.
      if (!test_enable || w_enter_sync) begin
        r_half <= 1'b0;
      end else if (w_take_first) begin
        r_half <= 1'b1;
      end else if (w_emit) begin
        r_half <= 1'b0;
      end
      if (w_enter_sync) begin
        r_seq        <= '0;
        DATA32_ATU_0 <= sync_pattern;
        DATA32_ATU_1 <= sync_pattern;
        DATA32_ATU_2 <= sync_pattern;
        DATA32_ATU_3 <= sync_pattern;
      end else if (w_emit) begin
        r_seq <= r_seq + 1'b1;
        if (!r_seq[0]) begin
          DATA32_ATU_0 <= w_word_g10;
          DATA32_ATU_1 <= w_word_g01;
        end else begin
          DATA32_ATU_2 <= w_word_g10;
          DATA32_ATU_3 <= w_word_g01;
        end
      end
    end
  end

  // Older samples are plain data holding registers and need no reset.
  always_ff @(posedge CLK) begin
    if (w_take_first) begin
      r_old_g10 <= DATA12_g10;
      r_old_g01 <= DATA12_g01;
    end
  end

  assign atu_active = (r_state != IDLE);

endmodule

// File: tb/tb_ldtu_atu_packer.sv
// tb_ldtu_atu_packer
// Directed self-checking bench for ldtu_atu_packer. Inputs change 1 ns after
// the rising edge and outputs are checked at the same point.
// Optional feature macro: LDTU_ATU_PARITY_EN (expected data words adapt).
module tb_ldtu_atu_packer;

  logic        CLK = 1'b0;
  logic        rst_b;
  logic        test_enable;
  logic        sample_valid;
  logic [11:0] DATA12_g01;
  logic [11:0] DATA12_g10;
  logic [31:0] sync_pattern;
  logic [31:0] DATA32_ATU_0, DATA32_ATU_1, DATA32_ATU_2, DATA32_ATU_3;
  logic        atu_load;
  logic        atu_active;
  logic [31:0] lanes [4];

  int n_tests = 0;
  int n_fail  = 0;

`ifdef LDTU_ATU_PARITY_EN
  localparam logic [31:0] EXP_P1_G10 = 32'hA0123456;
  localparam logic [31:0] EXP_P1_G01 = 32'h60789ABC;
  localparam logic [31:0] EXP_P2_G10 = 32'hA1001002;
  localparam logic [31:0] EXP_P2_G01 = 32'h41003004;
  localparam logic [31:0] EXP_R1_G10 = 32'hA0333444;
  localparam logic [31:0] EXP_R1_G01 = 32'h40555666;
`else
  localparam logic [31:0] EXP_P1_G10 = 32'h80123456;
  localparam logic [31:0] EXP_P1_G01 = 32'h40789ABC;
  localparam logic [31:0] EXP_P2_G10 = 32'h81001002;
  localparam logic [31:0] EXP_P2_G01 = 32'h41003004;
  localparam logic [31:0] EXP_R1_G10 = 32'h80333444;
  localparam logic [31:0] EXP_R1_G01 = 32'h40555666;
`endif

  ldtu_atu_packer dut (
    .CLK          (CLK),
    .rst_b        (rst_b),
    .test_enable  (test_enable),
    .sample_valid (sample_valid),
    .DATA12_g01   (DATA12_g01),
    .DATA12_g10   (DATA12_g10),
    .sync_pattern (sync_pattern),
    .DATA32_ATU_0 (DATA32_ATU_0),
    .DATA32_ATU_1 (DATA32_ATU_1),
    .DATA32_ATU_2 (DATA32_ATU_2),
    .DATA32_ATU_3 (DATA32_ATU_3),
    .atu_load     (atu_load),
    .atu_active   (atu_active)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    lanes[0] = DATA32_ATU_0;
    lanes[1] = DATA32_ATU_1;
    lanes[2] = DATA32_ATU_2;
    lanes[3] = DATA32_ATU_3;
  end

  // Reference word built straight from the documented field layout.
  function automatic logic [31:0] exp_word(input logic [1:0] tag, input int seq,
                                           input logic [11:0] older, input logic [11:0] newer);
    logic [31:0] w;
    w = {tag, 6'(seq), older, newer};
`ifdef LDTU_ATU_PARITY_EN
    w[29] = ^w[28:0];
`endif
    return w;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; test_enable = 1'b0; sample_valid = 1'b0;
    DATA12_g01 = '0; DATA12_g10 = '0; sync_pattern = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (lanes[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_lane%0d: got %h expected 00000000", i, lanes[i]);
      end
    end
    n_tests++;
    if (atu_load !== 1'b0 || atu_active !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: load=%b active=%b expected 0 0", atu_load, atu_active);
    end
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_sync();
    sync_pattern = 32'h5A5A5A5A; sample_valid = 1'b1;
    DATA12_g10 = 12'hFFF; DATA12_g01 = 12'hFFF; test_enable = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (lanes[i] !== 32'h5A5A5A5A) begin
        n_fail++; $display("FAIL sync_lane%0d: got %h expected 5a5a5a5a", i, lanes[i]);
      end
    end
    n_tests++;
    if (atu_load !== 1'b1 || atu_active !== 1'b1) begin
      n_fail++; $display("FAIL sync_ctrl: load=%b active=%b expected 1 1", atu_load, atu_active);
    end
    sync_pattern = 32'hDEADBEEF;
    step();
    n_tests++;
    if (atu_load !== 1'b0 || atu_active !== 1'b1 || DATA32_ATU_0 !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL sync_after: load=%b active=%b lane0=%h expected 0 1 5a5a5a5a",
                         atu_load, atu_active, DATA32_ATU_0);
    end
  endtask

  task automatic test_pair();
    sample_valid = 1'b1; DATA12_g10 = 12'h123; DATA12_g01 = 12'h789;
    step();
    n_tests++;
    if (atu_load !== 1'b0 || DATA32_ATU_0 !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL pair_first_half: load=%b lane0=%h expected 0 5a5a5a5a", atu_load, DATA32_ATU_0);
    end
    DATA12_g10 = 12'h456; DATA12_g01 = 12'hABC;
    step();
    n_tests++;
    if (DATA32_ATU_0 !== EXP_P1_G10) begin
      n_fail++; $display("FAIL pair1_lane0: got %h expected %h", DATA32_ATU_0, EXP_P1_G10);
    end
    n_tests++;
    if (DATA32_ATU_1 !== EXP_P1_G01) begin
      n_fail++; $display("FAIL pair1_lane1: got %h expected %h", DATA32_ATU_1, EXP_P1_G01);
    end
    n_tests++;
    if (DATA32_ATU_2 !== 32'h5A5A5A5A || DATA32_ATU_3 !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL pair1_hold23: got %h %h expected 5a5a5a5a", DATA32_ATU_2, DATA32_ATU_3);
    end
    n_tests++;
    if (atu_load !== 1'b1) begin
      n_fail++; $display("FAIL pair1_load: got %b expected 1", atu_load);
    end
    sample_valid = 1'b0;
    step();
    n_tests++;
    if (atu_load !== 1'b0) begin
      n_fail++; $display("FAIL pair1_load_drop: got %b expected 0", atu_load);
    end
  endtask

  task automatic test_pair_gap();
    sample_valid = 1'b1; DATA12_g10 = 12'h001; DATA12_g01 = 12'h003;
    step();
    sample_valid = 1'b0; DATA12_g10 = 12'hEEE; DATA12_g01 = 12'hEEE;
    step();
    step();
    n_tests++;
    if (atu_load !== 1'b0 || DATA32_ATU_2 !== 32'h5A5A5A5A) begin
      n_fail++; $display("FAIL gap_hold: load=%b lane2=%h expected 0 5a5a5a5a", atu_load, DATA32_ATU_2);
    end
    sample_valid = 1'b1; DATA12_g10 = 12'h002; DATA12_g01 = 12'h004;
    step();
    sample_valid = 1'b0;
    n_tests++;
    if (DATA32_ATU_2 !== EXP_P2_G10 || DATA32_ATU_3 !== EXP_P2_G01) begin
      n_fail++; $display("FAIL pair2_lane23: got %h %h expected %h %h",
                         DATA32_ATU_2, DATA32_ATU_3, EXP_P2_G10, EXP_P2_G01);
    end
    n_tests++;
    if (DATA32_ATU_0 !== EXP_P1_G10 || DATA32_ATU_1 !== EXP_P1_G01) begin
      n_fail++; $display("FAIL pair2_hold01: got %h %h expected %h %h",
                         DATA32_ATU_0, DATA32_ATU_1, EXP_P1_G10, EXP_P1_G01);
    end
  endtask

  task automatic test_disable();
    sample_valid = 1'b1; DATA12_g10 = 12'h111; DATA12_g01 = 12'h222;
    step();
    sample_valid = 1'b0; test_enable = 1'b0;
    step();
    n_tests++;
    if (atu_active !== 1'b0 || atu_load !== 1'b0) begin
      n_fail++; $display("FAIL disable_ctrl: active=%b load=%b expected 0 0", atu_active, atu_load);
    end
    n_tests++;
    if (DATA32_ATU_0 !== EXP_P1_G10 || DATA32_ATU_2 !== EXP_P2_G10) begin
      n_fail++; $display("FAIL disable_hold: got %h %h expected %h %h",
                         DATA32_ATU_0, DATA32_ATU_2, EXP_P1_G10, EXP_P2_G10);
    end
    sync_pattern = 32'hC3C3C3C3; test_enable = 1'b1;
    step();
    n_tests++;
    if (DATA32_ATU_0 !== 32'hC3C3C3C3 || DATA32_ATU_3 !== 32'hC3C3C3C3 || atu_load !== 1'b1) begin
      n_fail++; $display("FAIL resync: lane0=%h lane3=%h load=%b expected c3c3c3c3 c3c3c3c3 1",
                         DATA32_ATU_0, DATA32_ATU_3, atu_load);
    end
    step();
    sample_valid = 1'b1; DATA12_g10 = 12'h333; DATA12_g01 = 12'h555;
    step();
    DATA12_g10 = 12'h444; DATA12_g01 = 12'h666;
    step();
    sample_valid = 1'b0;
    n_tests++;
    if (DATA32_ATU_0 !== EXP_R1_G10 || DATA32_ATU_1 !== EXP_R1_G01) begin
      n_fail++; $display("FAIL resync_pair: got %h %h expected %h %h",
                         DATA32_ATU_0, DATA32_ATU_1, EXP_R1_G10, EXP_R1_G01);
    end
    n_tests++;
    if (DATA32_ATU_2 !== 32'hC3C3C3C3) begin
      n_fail++; $display("FAIL resync_hold2: got %h expected c3c3c3c3", DATA32_ATU_2);
    end
  endtask

  task automatic test_wrap();
    logic [11:0] o10, o01, n10, n01;
    logic [31:0] e10, e01;
    int          lb;
    test_enable = 1'b0;
    step();
    test_enable = 1'b1;
    step();
    step();
    sample_valid = 1'b1;
    for (int i = 0; i < 65; i++) begin
      o10 = 12'(i); o01 = 12'(i + 100); n10 = ~12'(i); n01 = 12'(i * 7 + 5);
      DATA12_g10 = o10; DATA12_g01 = o01;
      step();
      n_tests++;
      if (atu_load !== 1'b0) begin
        n_fail++; $display("FAIL wrap_load_half pair %0d: got %b expected 0", i + 1, atu_load);
      end
      DATA12_g10 = n10; DATA12_g01 = n01;
      step();
      lb  = (i % 2 == 0) ? 0 : 2;
      e10 = exp_word(2'b10, i % 64, o10, n10);
      e01 = exp_word(2'b01, i % 64, o01, n01);
      n_tests++;
      if (lanes[lb] !== e10 || lanes[lb + 1] !== e01 || atu_load !== 1'b1) begin
        n_fail++; $display("FAIL wrap_pair %0d: lanes %h %h load=%b expected %h %h 1",
                           i + 1, lanes[lb], lanes[lb + 1], atu_load, e10, e01);
      end
`ifdef LDTU_ATU_PARITY_EN
      n_tests++;
      if ((^lanes[lb][29:0]) !== 1'b0 || (^lanes[lb + 1][29:0]) !== 1'b0) begin
        n_fail++; $display("FAIL wrap_parity pair %0d: words %h %h", i + 1, lanes[lb], lanes[lb + 1]);
      end
`endif
    end
    sample_valid = 1'b0;
    n_tests++;
    if (DATA32_ATU_0[28:24] !== 5'd0 || DATA32_ATU_1[28:24] !== 5'd0) begin
      n_fail++; $display("FAIL wrap_seq0: got %h %h expected seq field 0", DATA32_ATU_0, DATA32_ATU_1);
    end
  endtask

  task automatic test_reset_mid();
    sample_valid = 1'b1; DATA12_g10 = 12'h0AA; DATA12_g01 = 12'h0BB;
    step();
    DATA12_g10 = 12'h0CC; DATA12_g01 = 12'h0DD;
    step();
    sample_valid = 1'b0;
    rst_b = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (lanes[i] !== 32'h0) begin
        n_fail++; $display("FAIL midreset_lane%0d: got %h expected 00000000", i, lanes[i]);
      end
    end
    n_tests++;
    if (atu_load !== 1'b0 || atu_active !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ctrl: load=%b active=%b expected 0 0", atu_load, atu_active);
    end
    step();
    rst_b = 1'b1; sync_pattern = 32'h0F0F0F0F;
    step();
    n_tests++;
    if (atu_active !== 1'b1 || DATA32_ATU_1 !== 32'h0F0F0F0F || atu_load !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_sync: active=%b lane1=%h load=%b expected 1 0f0f0f0f 1",
                         atu_active, DATA32_ATU_1, atu_load);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_pair();
    test_pair_gap();
    test_disable();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
